// File: rtl/simd_multiproc_top.sv
// simd_multiproc_top: vector command issuer, PE pool and round-robin shared memory.
// Optional macro HAZARD_CHECK_EN holds a command whose ranges overlap busy PE work.
module simd_sp_ram #(
  parameter int DATA_W = 16,
  parameter int AW = 14
) (
  input  logic              i_clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] r_mem [0:(1<<AW)-1];
  always_ff @(posedge i_clk)
    if (en) begin
      if (we) r_mem[addr] <= wdata;
      else rdata <= r_mem[addr];
    end
endmodule

module simd_shared_mem #(
  parameter int DATA_W = 16,
  parameter int AW = 14
) (
  input  logic              i_clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  simd_sp_ram #(.DATA_W(DATA_W), .AW(AW)) u_mem (
    .i_clk(i_clk), .en(en), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata)
  );
endmodule

module simd_pe_pool #(
  parameter int DATA_W = 16,
  parameter int AW = 14,
  parameter int LEN_W = 8,
  parameter int NUM_PE = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [2+3*AW+LEN_W-1:0] cmd,
  input  logic                    pop,
  output logic                    can_issue,
  output logic                    all_idle,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [AW-1:0]           mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata
);
  localparam int PW = NUM_PE > 1 ? $clog2(NUM_PE) : 1;
  localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_COPY = 2'd3;
  typedef enum logic [1:0] {IDLE, RD_A, RD_B, WR} state_t;
  state_t            st     [NUM_PE];
  logic [1:0]        op     [NUM_PE];
  logic [AW-1:0]     a_base [NUM_PE];
  logic [AW-1:0]     b_base [NUM_PE];
  logic [AW-1:0]     d_base [NUM_PE];
  logic [AW-1:0]     pe_addr[NUM_PE];
  logic [LEN_W-1:0]  len    [NUM_PE];
  logic [LEN_W-1:0]  idx    [NUM_PE];
  logic [DATA_W-1:0] a_reg  [NUM_PE];
  logic [DATA_W-1:0] b_reg  [NUM_PE];
  logic [DATA_W-1:0] a_eff  [NUM_PE];
  logic [DATA_W-1:0] b_eff  [NUM_PE];
  logic [DATA_W-1:0] res    [NUM_PE];
  logic [NUM_PE-1:0] pend, pend_a, req, gnt, ld;
  logic [PW-1:0]     ptr, g;
  logic              any, found;
  // a read granted last cycle has its data on mem_rdata now; bypass it into the operands
  always_comb begin
    for (int i = 0; i < NUM_PE; i++) begin
      req[i] = st[i] != IDLE;
      pe_addr[i] = (st[i] == WR ? d_base[i] : st[i] == RD_B ? b_base[i] : a_base[i]) + AW'(idx[i]);
      a_eff[i] = pend[i] && pend_a[i] ? mem_rdata : a_reg[i];
      b_eff[i] = pend[i] && !pend_a[i] ? mem_rdata : b_reg[i];
      res[i] = op[i] == OP_ADD ? a_eff[i] + b_eff[i] :
               op[i] == OP_SUB ? a_eff[i] - b_eff[i] :
               op[i] == OP_MUL ? DATA_W'(a_eff[i] * b_eff[i]) : a_eff[i];
    end
  end
  always_comb begin
    gnt = '0;
    g = ptr;
    any = 1'b0;
    for (int k = 0; k < NUM_PE; k++)
      if (!any && req[(int'(ptr) + k) % NUM_PE]) begin
        any = 1'b1;
        gnt[(int'(ptr) + k) % NUM_PE] = 1'b1;
        g = PW'((int'(ptr) + k) % NUM_PE);
      end
  end
  assign mem_en = any;
  assign mem_we = st[g] == WR;
  assign mem_addr = pe_addr[g];
  assign mem_wdata = res[g];
  always_comb begin
    ld = '0;
    found = 1'b0;
    all_idle = 1'b1;
    for (int i = 0; i < NUM_PE; i++) begin
      if (st[i] == IDLE && !found) begin
        found = 1'b1;
        ld[i] = pop;
      end
      if (st[i] != IDLE) all_idle = 1'b0;
    end
  end
`ifdef HAZARD_CHECK_EN
  logic [1:0]       c_op;
  logic [AW-1:0]    c_a, c_b, c_d;
  logic [LEN_W-1:0] c_len;
  logic             haz;
  assign {c_op, c_a, c_b, c_d, c_len} = cmd;
  function automatic logic ovl(input logic [AW-1:0] x, input logic [LEN_W-1:0] nx,
                               input logic [AW-1:0] y, input logic [LEN_W-1:0] ny);
    logic [AW:0] xs, xe, ys, ye;
    xs = {1'b0, x};
    ys = {1'b0, y};
    xe = xs + (AW+1)'(nx) - (AW+1)'(1);
    ye = ys + (AW+1)'(ny) - (AW+1)'(1);
    return nx != '0 && ny != '0 && xs <= ye && ys <= xe;
  endfunction
  always_comb begin
    haz = 1'b0;
    for (int i = 0; i < NUM_PE; i++)
      if (st[i] != IDLE)
        haz = haz | ovl(d_base[i], len[i], c_a, c_len) | ovl(d_base[i], len[i], c_d, c_len) |
              (c_op != OP_COPY && ovl(d_base[i], len[i], c_b, c_len)) |
              ovl(a_base[i], len[i], c_d, c_len) |
              (op[i] != OP_COPY && ovl(b_base[i], len[i], c_d, c_len));
  end
  assign can_issue = found && !haz;
`else
  assign can_issue = found;
`endif
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr <= '0;
      pend <= '0;
      for (int i = 0; i < NUM_PE; i++) st[i] <= IDLE;
    end else begin
      if (any) ptr <= g == PW'(NUM_PE-1) ? '0 : g + PW'(1);
      for (int i = 0; i < NUM_PE; i++) begin
        pend[i] <= gnt[i] && st[i] != WR;
        pend_a[i] <= st[i] == RD_A;
        if (pend[i] && pend_a[i]) a_reg[i] <= mem_rdata;
        if (pend[i] && !pend_a[i]) b_reg[i] <= mem_rdata;
        if (ld[i]) begin
          {op[i], a_base[i], b_base[i], d_base[i], len[i]} <= cmd;
          idx[i] <= '0;
          st[i] <= cmd[LEN_W-1:0] == '0 ? IDLE : RD_A;
        end else if (gnt[i]) begin
          st[i] <= st[i] == RD_A ? (op[i] == OP_COPY ? WR : RD_B) :
                   st[i] == RD_B ? WR :
                   idx[i] + LEN_W'(1) == len[i] ? IDLE : RD_A;
          if (st[i] == WR) idx[i] <= idx[i] + LEN_W'(1);
        end
      end
    end
  end
endmodule

module simd_multiproc_top #(
  parameter int DATA_W = 16,
  parameter int AW = 14,
  parameter int LEN_W = 8,
  parameter int NUM_PE = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [2+3*AW+LEN_W-1:0] queue_cmd,
  input  logic                    queue_empty,
  output logic                    issuer_rd_queue,
  output logic                    finished_task
);
  logic              can_issue, all_idle, mem_en, mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  assign issuer_rd_queue = !i_rst && !queue_empty && can_issue;
  simd_pe_pool #(.DATA_W(DATA_W), .AW(AW), .LEN_W(LEN_W), .NUM_PE(NUM_PE)) u_pool (
    .i_clk(i_clk), .i_rst(i_rst), .cmd(queue_cmd), .pop(issuer_rd_queue),
    .can_issue(can_issue), .all_idle(all_idle), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  simd_shared_mem #(.DATA_W(DATA_W), .AW(AW)) u_shared_mem (
    .i_clk(i_clk), .en(mem_en), .we(mem_we), .addr(mem_addr), .wdata(mem_wdata), .rdata(mem_rdata)
  );
  always_ff @(posedge i_clk) finished_task <= i_rst ? 1'b0 : queue_empty && all_idle;
endmodule

// File: tb/tb_simd_multiproc_top.sv
// tb_simd_multiproc_top: directed scoreboard bench for simd_multiproc_top.
module tb_simd_multiproc_top;
  localparam int DATA_W = 16, AW = 14, LEN_W = 8, NUM_PE = 4, CW = 2+3*AW+LEN_W;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic [CW-1:0] queue_cmd = '0;
  logic queue_empty = 1'b1;
  logic issuer_rd_queue, finished_task;
  simd_multiproc_top #(.DATA_W(DATA_W), .AW(AW), .LEN_W(LEN_W), .NUM_PE(NUM_PE)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .queue_cmd(queue_cmd), .queue_empty(queue_empty),
    .issuer_rd_queue(issuer_rd_queue), .finished_task(finished_task)
  );
  always #5 i_clk = ~i_clk;
  typedef struct {logic [AW-1:0] a; logic [DATA_W-1:0] d;} exp_t;
  logic [CW-1:0] q[$];
  exp_t sb[$];
  int pop_cyc[$];
  logic [DATA_W-1:0] mm [0:(1<<AW)-1];
  int cyc = 0, pops = 0, n_chk = 0, n_fail = 0, p0 = 0;
  logic pop_now;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic poke(int a, int v);
    dut.u_shared_mem.u_mem.r_mem[a] = DATA_W'(v);
    mm[a] = DATA_W'(v);
  endtask
  // queue the command and run it through the in-order reference model
  task automatic push(logic [1:0] op, int a, int b, int d, int len);
    logic [AW-1:0] ai, bi, di;
    logic [DATA_W-1:0] x, y, r;
    q.push_back({op, AW'(a), AW'(b), AW'(d), LEN_W'(len)});
    for (int i = 0; i < len; i++) begin
      ai = AW'(a + i);
      bi = AW'(b + i);
      di = AW'(d + i);
      x = mm[ai];
      y = mm[bi];
      r = op == 2'd0 ? x + y : op == 2'd1 ? x - y : op == 2'd2 ? DATA_W'(x * y) : x;
      mm[di] = r;
      sb.push_back('{di, r});
    end
  endtask
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check("mem_word", 32'(dut.u_shared_mem.u_mem.r_mem[e.a]), 32'(e.d));
    end
  endtask
  task automatic wait_done(int target);
    int k = 0;
    do begin
      @(posedge i_clk); #1;
      k++;
    end while (!(pops >= target && finished_task) && k < 3000);
    check("done_in_time", 32'(k < 3000), 1);
  endtask
  task automatic wait_pops(int target);
    int k = 0;
    while (pops < target && k < 500) begin
      @(posedge i_clk); #1;
      k++;
    end
    check("pop_in_time", 32'(pops >= target), 1);
  endtask
  function automatic logic [DATA_W-1:0] rd(int a);
    return dut.u_shared_mem.u_mem.r_mem[a];
  endfunction
  // external show-ahead queue: pop decided from the mid-cycle strobe, head updated after the edge
  initial forever begin
    @(negedge i_clk);
    pop_now = issuer_rd_queue;
    @(posedge i_clk);
    cyc++;
    if (pop_now) begin
      pops++;
      pop_cyc.push_back(cyc);
      if (q.size() > 0) void'(q.pop_front());
    end
    #1;
    queue_empty = q.size() == 0;
    queue_cmd = q.size() == 0 ? '0 : q[0];
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_pop", 32'(issuer_rd_queue), 0);
    check("rst_fin", 32'(finished_task), 0);
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    check("idle_pop1", 32'(issuer_rd_queue), 0);
    @(posedge i_clk); #1;
    check("fin_after_rst", 32'(finished_task), 1);
    check("idle_pop2", 32'(issuer_rd_queue), 0);
    for (int i = 0; i < 8; i++) begin
      poke(i, i + 1);
      poke(16 + i, 10 * (i + 1));
    end
    p0 = pops;
    push(2'd0, 0, 16, 32, 4);
    wait_done(p0 + 1);
    check("add_pops", 32'(pops - p0), 1);
    for (int i = 0; i < 4; i++) check("add_const", 32'(rd(32 + i)), 32'(11 * (i + 1)));
    drain();
    check("add_fin", 32'(finished_task), 1);
    poke(40, 'h100);
    poke(41, 'h100);
    poke(42, 3);
    poke(43, 5);
    poke('h3FFF, 'hABCD);
    poke(70, 'h5555);
    p0 = pops;
    push(2'd2, 40, 41, 50, 1);
    push(2'd1, 42, 43, 51, 1);
    push(2'd3, 'h3FFF, 0, 60, 2);
    push(2'd0, 0, 16, 70, 0);
    wait_done(p0 + 4);
    check("wrap_pops", 32'(pops - p0), 4);
    check("mul_wrap", 32'(rd(50)), 0);
    check("sub_wrap", 32'(rd(51)), 'hFFFE);
    check("copy_hi", 32'(rd(60)), 'hABCD);
    check("copy_wrap", 32'(rd(61)), 1);
    check("len0_untouched", 32'(rd(70)), 'h5555);
    drain();
    pop_cyc.delete();
    p0 = pops;
`ifdef HAZARD_CHECK_EN
    push(2'd0, 0, 16, 100, 8);
    push(2'd3, 100, 0, 200, 8);
    wait_done(p0 + 2);
    check("haz_hold", 32'(pop_cyc.size() >= 2 && pop_cyc[1] - pop_cyc[0] >= 25), 1);
`else
    push(2'd0, 0, 16, 100, 8);
    wait_done(p0 + 1);
    push(2'd3, 100, 0, 200, 8);
    wait_done(p0 + 2);
`endif
    check("haz_copy0", 32'(rd(200)), 11);
    check("haz_copy7", 32'(rd(207)), 88);
    drain();
    pop_cyc.delete();
    p0 = pops;
    for (int k = 0; k < NUM_PE + 1; k++) push(2'd0, 0, 16, 300 + 8 * k, 4);
    wait_pops(p0 + NUM_PE + 1);
    check("fin_while_busy", 32'(finished_task), 0);
    wait_done(p0 + NUM_PE + 1);
    check("burst_consec", 32'(pop_cyc.size() == NUM_PE + 1 && pop_cyc[NUM_PE-1] - pop_cyc[0] == NUM_PE - 1), 1);
    check("burst_last_waits", 32'(pop_cyc.size() == NUM_PE + 1 && pop_cyc[NUM_PE] - pop_cyc[NUM_PE-1] > 1), 1);
    drain();
    for (int i = 0; i < 8; i++) poke(500 + i, 'hEEEE);
    p0 = pops;
    q.push_back({2'd0, AW'(0), AW'(16), AW'(500), LEN_W'(8)});
    wait_pops(p0 + 1);
    repeat (9) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    check("midrst_pop", 32'(issuer_rd_queue), 0);
    check("midrst_fin", 32'(finished_task), 0);
    check("midrst_idle", 32'(dut.u_pool.all_idle), 1);
    for (int i = 0; i < 8; i++) check("midrst_mem", 32'(rd(500 + i)), i < 3 ? 32'(11 * (i + 1)) : 'hEEEE);
    i_rst = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check("fin_after_midrst", 32'(finished_task), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/simd_multiproc_top.md
# simd_multiproc_top

Top level of the SIMD multiprocessor. It pops vector commands from an external command queue and dispatches each one to a free processing element (PE) in a pool. The PEs run element-wise vector operations on a single-port shared memory through a round-robin arbiter. The block raises `finished_task` once the queue is drained and all work has retired.

## Interface
- `DATA_W`, 16: memory word width.
- `AW`, 14: word address width; shared memory depth is 2^AW.
- `LEN_W`, 8: vector length field width.
- `NUM_PE`, 4: processing elements in the pool (≥1).
- `i_clk`  in  1  sole clock; all state changes on the rising edge.
- `i_rst`  in  1  one clock; reset is synchronous and active-high.
- `queue_cmd`  in  `2+3*AW+LEN_W`  head-of-queue command `cmd_t`, MSB→LSB: `op[1:0]`, `a_addr`, `b_addr`, `d_addr`, `len`. Valid whenever `queue_empty`=0 (show-ahead).
- `queue_empty`  in  1  queue has no command.
- `issuer_rd_queue`  out  1  one-cycle pop strobe; the head command is accepted in that cycle.
- `finished_task`  out  1  all issued work complete and queue empty.
- Instance names (hierarchical preload/dump): `u_shared_mem.u_mem.r_mem` (array of 2^AW × DATA_W), `u_pool` (PE pool).

## Operation
- Ops: 00 ADD d=a+b; 01 SUB d=a−b; 10 MUL d=low DATA_W bits of a*b; 11 COPY d=a (b unused).
- Arithmetic wraps modulo 2^DATA_W.
- Element i uses `a_addr+i`, `b_addr+i`, `d_addr+i`, i = 0..len−1. Addresses wrap modulo 2^AW.
- `len`=0: command is popped and retired with no memory access.
- Issuer pops the head command when all hold: `queue_empty`=0, ≥1 PE idle, no hazard. The command loads into the lowest-index idle PE. At most one pop per cycle.
- PE FSM: IDLE → RD_A → RD_B (skipped for COPY) → WR → next element (RD_A) or IDLE after the last element. Each state waits until the arbiter grants it.
- Shared memory: single port, synchronous read with 1-cycle latency, write in the granted cycle. Contents are not cleared by reset.
- Arbiter: round-robin over PE requests, one grant per cycle. The pointer advances past the granted PE.
- `finished_task` = `queue_empty` & all PEs IDLE & no access in flight. It is registered.

## Timing
- Reset values: `issuer_rd_queue`=0, `finished_task`=0, all PEs IDLE, arbiter pointer=0.
- `issuer_rd_queue` is combinational from registered state and `queue_cmd`/`queue_empty`. The PE captures the command at that same edge and requests from the next cycle.
- A PE that finishes its last write is considered busy in that cycle. It becomes issuable in the following cycle.
- Per-element latency with no contention: 3 cycles for ADD/SUB/MUL, 2 for COPY. Write data is available the cycle after the RD_B (or RD_A) grant.
- `finished_task` rises 1 cycle after the completion condition holds and falls the cycle after it stops holding.
- Reset asserted mid-operation: all in-flight commands are abandoned, outputs go to 0 on the next edge, and words already written are kept.

## Configuration
- `HAZARD_CHECK_EN` defined: a head command is held (no pop) while any busy PE has a d-range overlapping the new command's a/b/d ranges, or an a/b-range overlapping the new d-range.
  - Ranges are `[addr, addr+len−1]`, compared as non-wrapping (AW+1)-bit values.
  - `len`=0 ranges never overlap.
- Not defined: no hazard check. Issue depends only on PE availability, and software guarantees ordering.

## Test plan
- Reset with `queue_empty`=1 throughout → `issuer_rd_queue` stays 0 and `finished_task`=1 by the 2nd cycle after `i_rst` falls.
- Setup for the ADD test: mem[0..3]={1,2,3,4}, mem[16..19]={10,20,30,40}.
  - ADD a=0 b=16 d=32 len=4 → exactly one pop pulse and mem[32..35]={11,22,33,44}.
  - `finished_task` then goes to 1.
- Wrap tests:
  - MUL 0x0100*0x0100 → 0x0000.
  - SUB 3−5 → 0xFFFE.
  - COPY of len=2 with a_addr=0x3FFF → reads 0x3FFF then 0x0000.
- Hazard test (macro on): ADD d=100 len=8, then COPY a=100 d=200 len=8.
  - The COPY is not popped until the ADD's PE is idle.
  - mem[200..207] equals the ADD results.
- Queue of NUM_PE+1 independent len=4 ADDs → the first NUM_PE pops occur on consecutive cycles. The last pop waits for a PE to return to idle, and `finished_task` stays 0 until all five results are written.
- Assert `i_rst` during a len=8 command after 3 elements → outputs 0 next cycle, PEs idle, and the first 3 destination words keep their new values.
